// File: rtl/pipe_reg_chain_pkg.sv
// rtl/pipe_reg_chain_pkg.sv - shared helpers for the valid/ready register pipeline
package pipe_reg_chain_pkg;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_reg_chain_stage.sv
// rtl/pipe_reg_chain_stage.sv - one valid/data stage of the register pipeline
module pipe_reg_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             adv_in,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Data only loads from a valid source so an empty stage keeps a stable value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= RESET_VAL;
        end else if (flush) begin
            valid <= 1'b0;
            data  <= RESET_VAL;
        end else if (adv_in) begin
            valid <= src_valid;
            if (src_valid) begin
                data <= src_data;
            end
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// rtl/pipe_reg_chain.sv - DEPTH-stage valid/ready register pipeline with flush and occupancy count
module pipe_reg_chain
    import pipe_reg_chain_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WIDTH-1:0]                in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH-1:0]                out_data,
    output logic [count_width(DEPTH)-1:0]   count
);

    localparam int CW = count_width(DEPTH);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] adv;
    logic [WIDTH-1:0] d [DEPTH];
    logic             in_xfer;
    logic             out_xfer;

    // A stage advances if it is empty or everything downstream of it advances.
    always_comb begin
        logic a;
        a = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            a      = a || !v[i];
            adv[i] = a;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             sv;
        logic [WIDTH-1:0] sd;
        if (i == 0) begin : g_first
            assign sv = in_valid;
            assign sd = in_data;
        end else begin : g_rest
            assign sv = v[i-1];
            assign sd = d[i-1];
        end

        pipe_reg_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .adv_in    (adv[i]),
            .src_valid (sv),
            .src_data  (sd),
            .valid     (v[i]),
            .data      (d[i])
        );
    end

    assign in_ready  = adv[0] && !flush;
    assign out_valid = v[DEPTH-1] && !flush;
    assign out_data  = d[DEPTH-1];

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (in_xfer && !out_xfer) begin
            count <= count + CW'(1);
        end else if (out_xfer && !in_xfer) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb/tb_pipe_reg_chain.sv - self-checking bench for pipe_reg_chain
module tb_pipe_reg_chain;

    localparam int W = 8;
    localparam int D = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   count;

    always #5 clk = ~clk;

    pipe_reg_chain #(
        .WIDTH     (W),
        .DEPTH     (D),
        .RESET_VAL (8'h00)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level model: each in-flight word carries its stage position.
    typedef struct {
        int         pos;
        logic [W-1:0] data;
    } word_t;

    word_t        mq[$];
    logic [W-1:0] got[$];
    bit           moved[D];
    bit           adv0;
    bit           exp_ir;
    bit           exp_ov;

    always @(negedge clk) begin
        chk("out_data_known", 32'($isunknown(out_data)), 32'd0);
        if (!rst_n) begin
            mq.delete();
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_count", 32'(count), 32'd0);
            chk("rst_out_data", 32'(out_data), 32'h00);
        end else begin
            adv0 = 1'b1;
            for (int k = 0; k < mq.size(); k++) begin
                if (k == 0) moved[k] = (mq[0].pos == D - 1) ? out_ready : 1'b1;
                else        moved[k] = (mq[k-1].pos > mq[k].pos + 1) || moved[k-1];
                if (mq[k].pos == 0) adv0 = moved[k];
            end
            exp_ov = (mq.size() > 0) && (mq[0].pos == D - 1) && !flush;
            exp_ir = adv0 && !flush;
            chk("in_ready", 32'(in_ready), 32'(exp_ir));
            chk("out_valid", 32'(out_valid), 32'(exp_ov));
            if (exp_ov) chk("out_data", 32'(out_data), 32'(mq[0].data));
            chk("count", 32'(count), 32'(mq.size()));
            if (out_valid && out_ready) got.push_back(out_data);
            if (flush) begin
                mq.delete();
            end else begin
                for (int k = 0; k < mq.size(); k++) if (moved[k]) mq[k].pos++;
                if (exp_ov && out_ready) void'(mq.pop_front());
                if (in_valid && exp_ir) mq.push_back('{pos: 0, data: in_data});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_got(input string name, input logic [31:0] exp_words, input int n);
        chk({name, "_len"}, 32'(got.size()), 32'(n));
        for (int i = 0; i < n && i < got.size(); i++)
            chk(name, 32'(got[i]), 32'(exp_words[8*(n-1-i) +: 8]));
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        #1;
        chk("init_in_ready", 32'(in_ready), 32'd1);
        chk("init_count", 32'(count), 32'd0);
        step(2);
        rst_n = 1'b1;
        step(1);

        // Streaming: A1..A4 back to back, out_ready high
        got.delete();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hA1 + 8'(i);
            if (i == 3) begin
                chk("stream_count", 32'(count), 32'd3);
                chk("stream_first_out", 32'(out_data), 32'hA1);
            end
            step(1);
        end
        in_valid = 1'b0;
        chk("stream_count_steady", 32'(count), 32'd3);
        step(4);
        chk_got("stream_out", 32'hA1A2A3A4, 4);

        // Backpressure fill then drain
        got.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h10 + 8'(i);
            if (i < 3) step(1);
        end
        chk("bp_in_ready_full", 32'(in_ready), 32'd0);
        chk("bp_count_full", 32'(count), 32'd3);
        step(2);
        chk("bp_still_held", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        step(1);
        in_valid = 1'b0;
        step(4);
        chk_got("bp_out", 32'h10111213, 4);

        // Bubble collapse behind a stalled output
        got.delete();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h55;
        step(1);
        in_valid = 1'b0;
        step(2);
        in_valid = 1'b1; in_data = 8'h66;
        step(1);
        in_valid = 1'b0;
        step(1);
        chk("bubble_count", 32'(count), 32'd2);
        chk("bubble_in_ready", 32'(in_ready), 32'd1);
        chk("bubble_head", 32'(out_data), 32'h55);

        // Fill to full, then simultaneous accept and deliver
        in_valid = 1'b1; in_data = 8'h70;
        step(1);
        in_data = 8'h77;
        chk("full_blocked", 32'(in_ready), 32'd0);
        chk("full_count", 32'(count), 32'd3);
        out_ready = 1'b1;
        #1;
        chk("full_ready", 32'(in_ready), 32'd1);
        step(1);
        in_valid = 1'b0;
        chk("simul_count", 32'(count), 32'd3);
        chk("simul_next_head", 32'(out_data), 32'h66);
        step(4);
        chk_got("simul_out", 32'h55667077, 4);

        // Flush with an input word offered
        got.delete();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hC0;
        step(1);
        in_data = 8'hC1;
        step(1);
        in_valid = 1'b0;
        step(1);
        flush = 1'b1; in_valid = 1'b1; in_data = 8'hC2;
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        step(1);
        flush = 1'b0; in_valid = 1'b0;
        chk("post_flush_count", 32'(count), 32'd0);
        chk("post_flush_data", 32'(out_data), 32'h00);
        chk("post_flush_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        step(3);
        chk("flush_no_accept", 32'(got.size()), 32'd0);

        // Asynchronous reset mid-stream
        in_valid = 1'b1; in_data = 8'hE0;
        step(1);
        in_data = 8'hE1;
        step(1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_data", 32'(out_data), 32'h00);
        chk("async_rst_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(3);
        chk("after_rst_count", 32'(count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_reg_chain.md
Name: pipe_reg_chain

Overview:
- Parametrised successor to the single-bit D flip-flop.
- A WIDTH-bit, DEPTH-stage register pipeline with per-stage valid bits and valid/ready backpressure.
- Supports synchronous flush, a reset value and an occupancy count.
- Used as the standard retiming/delay element between datapath blocks wherever a bare flop chain cannot stall.

Parameters:
- WIDTH, 8, data width in bits (>=1)
- DEPTH, 3, number of register stages (>=1)
- RESET_VAL, '0, value loaded into every data stage on reset and flush

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous flush; empties the pipeline at the next edge
- in_valid  input  1  upstream data valid
- in_ready  output  1  pipeline can accept in_data this cycle
- in_data  input  WIDTH  upstream data
- out_valid  output  1  last stage holds valid data
- out_ready  input  1  downstream accepts out_data this cycle
- out_data  output  WIDTH  data of last stage
- count  output  $clog2(DEPTH+1)  number of occupied stages

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- While rst_n=0, the following hold:
  - all stage valids = 0
  - all stage data = RESET_VAL
  - out_valid = 0, out_data = RESET_VAL, count = 0
  - in_ready = 1 (combinational from the empty state)
- Stage i (0 = input side, DEPTH-1 = output side) holds v[i] and d[i].
- Stage advance condition: adv[i] = !v[i] || adv[i+1], with adv[DEPTH] = out_ready.
  - Empty stages are filled even when downstream is stalled (bubble collapse).
- Stage update when adv[i]=1 at an edge:
  - v[i] <= v[i-1], d[i] <= d[i-1]
  - stage 0 takes in_valid and in_data
- When adv[i]=0, the stage holds both v[i] and d[i].
- d[i] is loaded only when its source is valid; data of an empty stage is don't-care but stable.
- Handshake signals:
  - in_ready = adv[0] && !flush
  - out_valid = v[DEPTH-1] && !flush
  - out_data = d[DEPTH-1]
- Transfers occur only when valid && ready on the same edge.
- in_valid must not depend on in_ready. Upstream holds in_data stable while in_valid=1 and in_ready=0.
- Latency: a word accepted at edge N appears at out_valid after edge N+DEPTH-1 when unstalled (DEPTH cycles in flight). Throughput is 1 word/cycle.
- The in_ready path is a combinational chain through all DEPTH stages. No skid buffer is used; this is accepted.
- Full:
  - When all v=1 and out_ready=0, in_ready=0 and nothing moves.
  - When all v=1 and out_ready=1, simultaneous accept and deliver occur and count is unchanged.
- Flush:
  - At the edge with flush=1, all v <= 0 and all d <= RESET_VAL.
  - No transfer is counted in the flush cycle: in_ready=0 and out_valid=0 during flush.
- count = popcount(v), registered. It updates +1 on an input transfer only, -1 on an output transfer only, and is unchanged when both occur. Reset or flush sets it to 0.
- Reset mid-operation: asynchronous clear of all state. In-flight data is lost; no partial outputs.
- X-safety: out_data while out_valid=0 must still be a registered value, never X after reset.

Decomposition:
- No shared package types are needed.
- Define the count width as a localparam derived from DEPTH.
- Natural sub-module: pipe_reg_stage, with signals:
  - valid/data registers
  - adv_in
  - load-enable
  - flush
  - RESET_VAL
- It is instantiated DEPTH times by a generate loop.
- The top level derives the adv chain and count.

Test Plan:
- Reset: assert rst_n=0 mid-stream, then release. Required: out_valid=0, out_data=8'h00, count=0 and in_ready=1 immediately on assertion, independent of clk.
- Streaming: WIDTH=8, DEPTH=3, out_ready=1; drive 8'hA1, 8'hA2, 8'hA3, 8'hA4 on consecutive cycles. Required: the same sequence on out_data starting 2 edges after the first accept, one per cycle, with count steady at 3.
- Backpressure fill: out_ready=0; push 8'h10, 8'h11, 8'h12, 8'h13. Required: in_ready drops after 3 accepts, count=3 and 8'h13 is held upstream. Raise out_ready: 8'h10, 8'h11, 8'h12, 8'h13 drain in order with no loss or duplicates.
- Bubble collapse: inject 8'h55, idle 2 cycles, inject 8'h66 with out_ready=0. Required: both words end in stages 2 and 1, count=2 and in_ready=1.
- Full simultaneous transfer: full pipeline, out_ready=1 and in_valid=1 with 8'h77. Required: one word delivered, 8'h77 accepted the same edge and count remains 3.
- Flush: load 8'hC0 and 8'hC1, then assert flush with in_valid=1. Required: in_ready=0 and out_valid=0 during flush; next cycle count=0, out_data=RESET_VAL and the input word was not accepted.
